// File: rtl/pianotiles_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pianotiles_pkg
//  Brief    : Shared widths, arbiter state encoding and colour constants.
//  Revision : 1.0
// ============================================================================
package pianotiles_pkg;

    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_BURST = 2'd1;
    localparam logic [1:0] ARB_GAP   = 2'd2;

    localparam logic [CW-1:0] WHITE = 3'b111;
    localparam logic [CW-1:0] RED   = 3'b100;

endpackage
`default_nettype wire

// File: rtl/plot_prio_pick.sv
`default_nettype none
// ============================================================================
//  Module   : plot_prio_pick
//  Brief    : Combinational rotating priority encoder; returns the first set
//             request at or after the start index (index 0 when RR disabled).
//  Revision : 1.0
// ============================================================================
module plot_prio_pick #(
    parameter int N_REQ = 5,
    parameter int IW    = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic             rr_en,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    logic [IW-1:0] w_start;
    logic [IW:0]   w_cand_wide;
    logic [IW-1:0] w_cand;

    assign w_start = rr_en ? ptr : '0;

    always_comb begin
        onehot      = '0;
        idx         = '0;
        valid       = 1'b0;
        w_cand_wide = '0;
        w_cand      = '0;
        // Walk candidates in priority order, wrapping past the top index.
        for (int k = 0; k < N_REQ; k++) begin
            w_cand_wide = {1'b0, w_start} + (IW+1)'(k);
            if (w_cand_wide >= (IW+1)'(N_REQ))
                w_cand_wide = w_cand_wide - (IW+1)'(N_REQ);
            w_cand = w_cand_wide[IW-1:0];
            if (!valid && req[w_cand]) begin
                valid          = 1'b1;
                idx            = w_cand;
                onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_plot_arbiter
//  Brief    : Burst-granting arbiter sharing the vga_adapter pixel port among
//             N_REQ writers; registered plot stream, grant/abort/busy status.
//  Revision : 1.0
// ============================================================================
module vga_plot_arbiter
    import pianotiles_pkg::*;
#(
    parameter int N_REQ   = 5,
    parameter int RR_EN   = 0,
    parameter int TIMEOUT = 1023
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_plot,
    input  logic [N_REQ-1:0]   req_last,
    input  logic [N_REQ*XW-1:0] req_x,
    input  logic [N_REQ*YW-1:0] req_y,
    input  logic [N_REQ*CW-1:0] req_color,
    output logic [N_REQ-1:0]   grant,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic [CW-1:0]      colour,
    output logic               plot,
    output logic [N_REQ-1:0]   burst_done,
    output logic               abort,
    output logic               busy
);

    localparam int c_IW = $clog2(N_REQ);
    localparam int c_TW = $clog2(TIMEOUT + 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [N_REQ-1:0] r_grant;
    logic [c_IW-1:0]  r_win;
    logic [c_IW-1:0]  r_ptr;
    logic [c_TW-1:0]  r_tmo;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [CW-1:0]    r_col;
    logic             r_plot;
    logic [N_REQ-1:0] r_done;
    logic             r_abort;

    logic [N_REQ-1:0] w_pick_onehot;
    logic [c_IW-1:0]  w_pick_idx;
    logic             w_pick_valid;
    logic             w_fwd;
    logic             w_last;
    logic             w_drop;
    logic             w_tmo_hit;
    logic             w_end;
    logic             w_abort;
    logic [c_TW-1:0]  w_tmo_next;
    logic [c_IW-1:0]  w_ptr_next;

    plot_prio_pick #(
        .N_REQ (N_REQ),
        .IW    (c_IW)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .rr_en  (RR_EN != 0),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .valid  (w_pick_valid)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!resetn)
            r_state <= ARB_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE:  if (w_pick_valid) w_state_next = ARB_BURST;
            ARB_BURST: if (w_end)        w_state_next = ARB_GAP;
            ARB_GAP:                     w_state_next = ARB_IDLE;
            default:                     w_state_next = ARB_IDLE;
        endcase
    end

    // Burst control decode; only the granted writer's strobes are looked at.
    always_comb begin
        w_fwd      = 1'b0;
        w_last     = 1'b0;
        w_drop     = 1'b0;
        w_tmo_hit  = 1'b0;
        w_tmo_next = r_tmo + 1'b1;
        if (r_state == ARB_BURST) begin
            w_fwd     = r_grant[r_win] && req_plot[r_win];
            w_last    = w_fwd && req_last[r_win];
            w_drop    = !req[r_win] && !w_last;
            w_tmo_hit = !w_fwd && (w_tmo_next == c_TW'(TIMEOUT));
        end
        w_end      = w_last || w_drop || w_tmo_hit;
        w_abort    = (w_drop || w_tmo_hit) && !w_last;
        w_ptr_next = (r_win == c_IW'(N_REQ - 1)) ? '0 : r_win + 1'b1;
    end

    // Registered grant, pixel stream and status pulses.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_grant <= '0;
            r_win   <= '0;
            r_ptr   <= '0;
            r_tmo   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_col   <= '0;
            r_plot  <= 1'b0;
            r_done  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_plot  <= w_fwd;
            r_done  <= w_last ? r_grant : '0;
            r_abort <= w_abort;
            if (w_fwd) begin
                r_x   <= req_x[r_win*XW +: XW];
                r_y   <= req_y[r_win*YW +: YW];
                r_col <= req_color[r_win*CW +: CW];
            end
            case (r_state)
                ARB_IDLE: begin
                    r_tmo <= '0;
                    if (w_pick_valid) begin
                        r_grant <= w_pick_onehot;
                        r_win   <= w_pick_idx;
                    end
                end
                ARB_BURST: begin
                    if (w_end) begin
                        r_grant <= '0;
                        r_ptr   <= w_ptr_next;
                        r_tmo   <= '0;
                    end else if (w_fwd) begin
                        r_tmo <= '0;
                    end else begin
                        r_tmo <= w_tmo_next;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_tmo   <= '0;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign x          = r_x;
    assign y          = r_y;
    assign colour     = r_col;
    assign plot       = r_plot;
    assign burst_done = r_done;
    assign abort      = r_abort;
    assign busy       = (r_state != ARB_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_plot_arbiter
//  Brief    : Directed self-checking bench; fixed-priority and round-robin
//             instances share one stimulus bus.
//  Revision : 1.0
// ============================================================================
module tb_vga_plot_arbiter;

    logic        clock = 1'b0;
    logic        resetn;
    logic [4:0]  req, req_plot, req_last;
    logic [44:0] req_x;
    logic [39:0] req_y;
    logic [14:0] req_color;

    logic [4:0]  a_grant, a_done, b_grant, b_done;
    logic [8:0]  a_x, b_x;
    logic [7:0]  a_y, b_y;
    logic [2:0]  a_col, b_col;
    logic        a_plot, a_abort, a_busy, b_plot, b_abort, b_busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    vga_plot_arbiter #(.N_REQ(5), .RR_EN(0), .TIMEOUT(8)) dut_a (
        .clock(clock), .resetn(resetn), .req(req), .req_plot(req_plot),
        .req_last(req_last), .req_x(req_x), .req_y(req_y), .req_color(req_color),
        .grant(a_grant), .x(a_x), .y(a_y), .colour(a_col), .plot(a_plot),
        .burst_done(a_done), .abort(a_abort), .busy(a_busy)
    );

    vga_plot_arbiter #(.N_REQ(5), .RR_EN(1), .TIMEOUT(8)) dut_b (
        .clock(clock), .resetn(resetn), .req(req), .req_plot(req_plot),
        .req_last(req_last), .req_x(req_x), .req_y(req_y), .req_color(req_color),
        .grant(b_grant), .x(b_x), .y(b_y), .colour(b_col), .plot(b_plot),
        .burst_done(b_done), .abort(b_abort), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pix(input int i, input logic [8:0] px, input logic [7:0] py,
                           input logic [2:0] pc, input logic pl, input logic lst);
        req_x[9*i +: 9]     = px;
        req_y[8*i +: 8]     = py;
        req_color[3*i +: 3] = pc;
        req_plot[i]         = pl;
        req_last[i]         = lst;
    endtask

    task automatic clr();
        req = '0; req_plot = '0; req_last = '0;
        req_x = '0; req_y = '0; req_color = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clr();
        cyc();
        cyc();
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  cnt;
        bit  seen;
        int  w;

        // Reset state
        do_reset();
        check("rst_grant", 32'(a_grant), 32'h0);
        check("rst_plot",  32'(a_plot),  32'h0);
        check("rst_xyc",   32'({a_x, a_y, a_col}), 32'h0);
        check("rst_done",  32'(a_done),  32'h0);
        check("rst_abort", 32'(a_abort), 32'h0);
        check("rst_busy",  32'(a_busy),  32'h0);
        check("rst_b_grant", 32'(b_grant), 32'h0);

        // Three-pixel burst from requester 1
        req[1] = 1'b1;
        cyc();
        check("t1_grant", 32'(a_grant), 32'h02);
        check("t1_plot_idle", 32'(a_plot), 32'h0);
        set_pix(1, 9'd10, 8'd5, 3'b111, 1'b1, 1'b0);
        cyc();
        check("t1_plot0", 32'(a_plot), 32'h1);
        check("t1_x0", 32'(a_x), 32'd10);
        check("t1_y0", 32'(a_y), 32'd5);
        check("t1_c0", 32'(a_col), 32'h7);
        set_pix(1, 9'd11, 8'd5, 3'b111, 1'b1, 1'b0);
        cyc();
        check("t1_x1", 32'(a_x), 32'd11);
        check("t1_done_early", 32'(a_done), 32'h0);
        set_pix(1, 9'd12, 8'd5, 3'b111, 1'b1, 1'b1);
        cyc();
        check("t1_plot2", 32'(a_plot), 32'h1);
        check("t1_x2", 32'(a_x), 32'd12);
        check("t1_done", 32'(a_done), 32'h02);
        check("t1_grant_clr", 32'(a_grant), 32'h0);
        check("t1_busy_gap", 32'(a_busy), 32'h1);
        clr();
        cyc();
        check("t1_gap_plot", 32'(a_plot), 32'h0);
        check("t1_idle", 32'(a_busy), 32'h0);

        // Fixed priority: req 1 and 4 together
        do_reset();
        req = 5'b10010;
        cyc();
        check("t2_grant1", 32'(a_grant), 32'h02);
        set_pix(1, 9'd20, 8'd6, 3'b100, 1'b1, 1'b1);
        cyc();
        check("t2_done1", 32'(a_done), 32'h02);
        check("t2_x1", 32'(a_x), 32'd20);
        req[1] = 1'b0; req_plot = '0; req_last = '0;
        cyc();
        check("t2_gap_grant", 32'(a_grant), 32'h0);
        check("t2_gap_plot", 32'(a_plot), 32'h0);
        cyc();
        check("t2_grant4", 32'(a_grant), 32'h10);
        set_pix(4, 9'd300, 8'd50, 3'b001, 1'b1, 1'b1);
        cyc();
        check("t2_done4", 32'(a_done), 32'h10);
        check("t2_x4", 32'(a_x), 32'd300);
        check("t2_y4", 32'(a_y), 32'd50);
        clr();
        cyc();

        // Round-robin alternation between requesters 0 and 2
        do_reset();
        req = 5'b00101;
        for (int i = 0; i < 4; i++) begin
            w = (i % 2 == 1) ? 2 : 0;
            cyc();
            check("rr_grant", 32'(b_grant), 32'(1) << w);
            set_pix(w, 9'(i), 8'(i), 3'b111, 1'b1, 1'b1);
            cyc();
            check("rr_done", 32'(b_done), 32'(1) << w);
            set_pix(w, 9'd0, 8'd0, 3'b000, 1'b0, 1'b0);
            cyc();
            check("rr_idle", 32'(b_busy), 32'h0);
        end

        // Abort: requester 3 drops after two pixels
        do_reset();
        req[3] = 1'b1;
        cyc();
        check("ab_grant", 32'(a_grant), 32'h08);
        set_pix(3, 9'd1, 8'd2, 3'b010, 1'b1, 1'b0);
        cyc();
        set_pix(3, 9'd2, 8'd2, 3'b010, 1'b1, 1'b0);
        cyc();
        check("ab_x2", 32'(a_x), 32'd2);
        clr();
        cyc();
        check("ab_abort", 32'(a_abort), 32'h1);
        check("ab_done", 32'(a_done), 32'h0);
        check("ab_grant_clr", 32'(a_grant), 32'h0);
        check("ab_plot", 32'(a_plot), 32'h0);
        cyc();
        check("ab_pulse_end", 32'(a_abort), 32'h0);
        check("ab_idle", 32'(a_busy), 32'h0);

        // Timeout: grant held with no plot strobes
        do_reset();
        req[2] = 1'b1;
        cyc();
        check("to_grant", 32'(a_grant), 32'h04);
        cnt  = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cyc();
            cnt++;
            if (a_abort) seen = 1'b1;
        end
        check("to_seen", 32'(seen), 32'h1);
        check("to_cycles", 32'(cnt), 32'd8);
        check("to_grant_clr", 32'(a_grant), 32'h0);
        req = '0;
        cyc();
        check("to_idle", 32'(a_busy), 32'h0);

        // Non-granted strobe ignored, then reset mid-burst
        do_reset();
        req[2] = 1'b1;
        cyc();
        set_pix(0, 9'd77, 8'd77, 3'b111, 1'b1, 1'b0);
        cyc();
        check("ng_plot", 32'(a_plot), 32'h0);
        check("ng_x", 32'(a_x), 32'h0);
        set_pix(2, 9'd30, 8'd31, 3'b011, 1'b1, 1'b0);
        cyc();
        check("ng_own_plot", 32'(a_plot), 32'h1);
        check("ng_own_x", 32'(a_x), 32'd30);
        resetn = 1'b0;
        cyc();
        check("mr_grant", 32'(a_grant), 32'h0);
        check("mr_plot", 32'(a_plot), 32'h0);
        check("mr_xyc", 32'({a_x, a_y, a_col}), 32'h0);
        check("mr_busy", 32'(a_busy), 32'h0);
        check("mr_flags", 32'({a_done, a_abort}), 32'h0);
        resetn = 1'b1;
        clr();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
